// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard that sits between ID and EX.
// - creg_addr_t : architectural register address (x0..x31)
// - sb_state_t  : issue controller state (normal issue or fence drain)
// - SB_* widths : default register count and counter widths
package issue_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_CNT_W = 2;
    localparam int SB_OUT_W = 3;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic {
        SB_RUN,
        SB_DRAIN
    } sb_state_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Bundle of the ID/EX/WB handshake signals seen by the issue scoreboard.
// modport slave  : the scoreboard (takes ID/EX/WB inputs, drives issue/stall/status)
// modport master : the pipeline side driving ID/EX/WB and observing the scoreboard
interface issue_scoreboard_if
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int OUT_W = SB_OUT_W
);
    logic             id_valid;
    creg_addr_t       id_ra1;
    creg_addr_t       id_ra2;
    logic             id_use1;
    logic             id_use2;
    logic             id_regwrite;
    creg_addr_t       id_wa;
    logic             id_fence;
    logic             ex_ready;
    logic             flush;
    logic             wb_valid;
    logic             wb_regwrite;
    creg_addr_t       wb_wa;
    logic             issue;
    logic             stall_id;
    logic [NREG-1:0]  pending_mask;
    logic [OUT_W-1:0] outstanding;
    logic             fsm_drain;

    modport slave (
        input  id_valid, id_ra1, id_ra2, id_use1, id_use2, id_regwrite, id_wa,
               id_fence, ex_ready, flush, wb_valid, wb_regwrite, wb_wa,
        output issue, stall_id, pending_mask, outstanding, fsm_drain
    );

    modport master (
        output id_valid, id_ra1, id_ra2, id_use1, id_use2, id_regwrite, id_wa,
               id_fence, ex_ready, flush, wb_valid, wb_regwrite, wb_wa,
        input  issue, stall_id, pending_mask, outstanding, fsm_drain
    );
endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// sb_counter: saturating up/down counter.
// Ports: clk, reset (sync, active high), inc, dec -> count, is_zero, is_max.
// inc and dec together leave the count unchanged; it never wraps past 0 or max.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero,
    output logic         is_max
);

    assign is_zero = (count == '0);
    assign is_max  = (count == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && !is_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && !is_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW interlock between decode and execute.
// Ports: clk, reset (sync, active high), sb (issue_scoreboard_if.slave).
//   Inputs via sb : ID instruction fields, ex_ready, flush, WB retire.
//   Outputs via sb: issue, stall_id, pending_mask, outstanding, fsm_drain.
// One pending-write counter per register plus a global outstanding counter.
// A same-cycle WB retire is treated as already written (write-first regfile).
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W,
    parameter int OUT_W = SB_OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    issue_scoreboard_if.slave sb
);

    logic             ret;
    logic             do_inc;
    logic             raw;
    logic             full;
    logic             permit;
    logic             issue_int;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic [NREG-1:0]  eff_nz;
    logic [NREG-1:0]  pend_zero;
    logic [NREG-1:0]  pend_max;
    logic [CNT_W-1:0] pend [NREG];
    logic [OUT_W-1:0] out_cnt;
    logic             out_zero;
    logic             out_max;
    logic             out_eff_zero;
    sb_state_t        state;
    sb_state_t        state_next;

    assign ret    = sb.wb_valid & sb.wb_regwrite & (sb.wb_wa != '0);
    assign do_inc = issue_int & sb.id_regwrite & (sb.id_wa != '0);

    // eff_nz is the pending count after subtracting a same-cycle retire.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign inc_vec[g] = do_inc & (sb.id_wa == creg_addr_t'(g));
        assign dec_vec[g] = ret & (sb.wb_wa == creg_addr_t'(g));
        assign eff_nz[g]  = ((pend[g] - CNT_W'(dec_vec[g])) != '0);

        sb_counter #(.W(CNT_W)) u_pend (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc_vec[g]),
            .dec     (dec_vec[g]),
            .count   (pend[g]),
            .is_zero (pend_zero[g]),
            .is_max  (pend_max[g])
        );
    end

    sb_counter #(.W(OUT_W)) u_outstanding (
        .clk     (clk),
        .reset   (reset),
        .inc     (do_inc),
        .dec     (ret),
        .count   (out_cnt),
        .is_zero (out_zero),
        .is_max  (out_max)
    );

    // Outstanding count as seen after this cycle's retire.
    assign out_eff_zero = ret ? (out_cnt == OUT_W'(1)) : out_zero;

    assign raw  = (sb.id_use1 & eff_nz[sb.id_ra1]) | (sb.id_use2 & eff_nz[sb.id_ra2]);

    // Capacity check deliberately ignores a same-cycle retire.
    assign full = sb.id_regwrite & (sb.id_wa != '0) & (pend_max[sb.id_wa] | out_max);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SB_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A fence may only issue once every earlier write has retired; while
    // waiting the controller sits in DRAIN. A flush kills the fence.
    always_comb begin
        state_next = state;
        permit     = 1'b0;
        case (state)
            SB_RUN: begin
                permit = ~sb.id_fence | out_eff_zero;
                if (sb.id_valid && sb.id_fence && !sb.flush && !out_eff_zero) begin
                    state_next = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                permit = out_eff_zero;
                if (out_eff_zero || sb.flush) begin
                    state_next = SB_RUN;
                end
            end
            default: begin
                state_next = SB_RUN;
            end
        endcase
    end

    assign issue_int       = sb.id_valid & ~sb.flush & sb.ex_ready & ~raw & ~full & permit;
    assign sb.issue        = issue_int;
    assign sb.stall_id     = sb.id_valid & ~sb.flush & ~issue_int;
    assign sb.pending_mask = ~pend_zero;
    assign sb.outstanding  = out_cnt;
    assign sb.fsm_drain    = (state == SB_DRAIN);

    // Retiring a register with nothing pending is a pipeline protocol error.
    a_no_retire_underflow: assert property (
        @(posedge clk) disable iff (reset) ret |-> !pend_zero[sb.wb_wa]
    );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed vectors with literal
// expectations, plus a register-level behavioural model checked every cycle.
module tb_issue_scoreboard;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    issue_scoreboard_if #(.NREG(32), .OUT_W(3)) sb_bus ();

    issue_scoreboard #(.NREG(32), .CNT_W(2), .OUT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pending write count per register, total in flight,
    // and whether a fence is waiting for writes to drain.
    int pend_m [32];
    int out_m;
    bit drain_m;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model compare and update, once per cycle on the falling edge while the
    // inputs are stable for the coming rising edge.
    always begin
        logic        ret;
        int          eff1, eff2, oe;
        logic        raw, full, permit, e_issue, e_stall;
        logic [31:0] e_mask;
        @(negedge clk);
        ret  = sb_bus.wb_valid && sb_bus.wb_regwrite && (sb_bus.wb_wa != 0);
        eff1 = pend_m[sb_bus.id_ra1] - ((ret && sb_bus.wb_wa == sb_bus.id_ra1) ? 1 : 0);
        eff2 = pend_m[sb_bus.id_ra2] - ((ret && sb_bus.wb_wa == sb_bus.id_ra2) ? 1 : 0);
        raw  = (sb_bus.id_use1 && eff1 != 0) || (sb_bus.id_use2 && eff2 != 0);
        full = sb_bus.id_regwrite && sb_bus.id_wa != 0 &&
               (pend_m[sb_bus.id_wa] == 3 || out_m == 7);
        oe   = out_m - (ret ? 1 : 0);
        permit  = drain_m ? (oe == 0) : (!sb_bus.id_fence || oe == 0);
        e_issue = sb_bus.id_valid && !sb_bus.flush && sb_bus.ex_ready && !raw && !full && permit;
        e_stall = sb_bus.id_valid && !sb_bus.flush && !e_issue;
        e_mask  = '0;
        for (int r = 0; r < 32; r++) e_mask[r] = (pend_m[r] != 0);

        cmp("model.issue",        32'(sb_bus.issue),        32'(e_issue));
        cmp("model.stall_id",     32'(sb_bus.stall_id),     32'(e_stall));
        cmp("model.pending_mask", sb_bus.pending_mask,       e_mask);
        cmp("model.outstanding",  32'(sb_bus.outstanding),  32'(out_m));
        cmp("model.fsm_drain",    32'(sb_bus.fsm_drain),    32'(drain_m));

        if (reset) begin
            for (int r = 0; r < 32; r++) pend_m[r] = 0;
            out_m   = 0;
            drain_m = 0;
        end else begin
            if (drain_m) begin
                if (oe == 0 || sb_bus.flush) drain_m = 0;
            end else if (sb_bus.id_valid && sb_bus.id_fence && !sb_bus.flush && oe != 0) begin
                drain_m = 1;
            end
            if (e_issue && sb_bus.id_regwrite && sb_bus.id_wa != 0) begin
                pend_m[sb_bus.id_wa]++;
                out_m++;
            end
            if (ret && pend_m[sb_bus.wb_wa] > 0) begin
                pend_m[sb_bus.wb_wa]--;
                out_m--;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(
        input logic       rst,
        input logic       v,
        input logic [4:0] ra1, input logic use1,
        input logic [4:0] ra2, input logic use2,
        input logic       rw,  input logic [4:0] wa,
        input logic       fence,
        input logic       exr,
        input logic       fl,
        input logic       wbv, input logic [4:0] wbwa
    );
        @(posedge clk);
        #1;
        reset              = rst;
        sb_bus.id_valid    = v;
        sb_bus.id_ra1      = ra1;
        sb_bus.id_use1     = use1;
        sb_bus.id_ra2      = ra2;
        sb_bus.id_use2     = use2;
        sb_bus.id_regwrite = rw;
        sb_bus.id_wa       = wa;
        sb_bus.id_fence    = fence;
        sb_bus.ex_ready    = exr;
        sb_bus.flush       = fl;
        sb_bus.wb_valid    = wbv;
        sb_bus.wb_regwrite = wbv;
        sb_bus.wb_wa       = wbwa;
    endtask

    task automatic idle(input logic wbv, input logic [4:0] wbwa);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, wbv, wbwa);
    endtask

    task automatic wr(input logic [4:0] wa, input logic wbv, input logic [4:0] wbwa);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, wa, 0, 1, 0, wbv, wbwa);
    endtask

    task automatic fence(input logic fl, input logic wbv, input logic [4:0] wbwa);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, fl, wbv, wbwa);
    endtask

    // Hand-computed expectation for the cycle just applied.
    task automatic checkOutput(
        input string       name,
        input logic        e_issue,
        input logic        e_stall,
        input logic [31:0] e_mask,
        input logic [2:0]  e_out,
        input logic        e_drain
    );
        #5;
        total++;
        if (sb_bus.issue !== e_issue || sb_bus.stall_id !== e_stall ||
            sb_bus.pending_mask !== e_mask || sb_bus.outstanding !== e_out ||
            sb_bus.fsm_drain !== e_drain) begin
            bad++;
            $display("[TB] FAIL %s: got issue=%b stall=%b mask=%h out=%0d drain=%b, expected issue=%b stall=%b mask=%h out=%0d drain=%b",
                     name, sb_bus.issue, sb_bus.stall_id, sb_bus.pending_mask,
                     sb_bus.outstanding, sb_bus.fsm_drain,
                     e_issue, e_stall, e_mask, e_out, e_drain);
        end
    endtask

    localparam logic [31:0] B3 = 32'h1 << 3;
    localparam logic [31:0] B4 = 32'h1 << 4;
    localparam logic [31:0] B5 = 32'h1 << 5;
    localparam logic [31:0] B7 = 32'h1 << 7;
    localparam logic [31:0] B8 = 32'h1 << 8;
    localparam logic [31:0] B9 = 32'h1 << 9;

    initial begin
        total = 0;
        bad   = 0;
        out_m = 0;
        drain_m = 0;
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        reset = 1'b1;
        sb_bus.id_valid = 0; sb_bus.id_ra1 = 0; sb_bus.id_ra2 = 0;
        sb_bus.id_use1 = 0; sb_bus.id_use2 = 0; sb_bus.id_regwrite = 0;
        sb_bus.id_wa = 0; sb_bus.id_fence = 0; sb_bus.ex_ready = 1;
        sb_bus.flush = 0; sb_bus.wb_valid = 0; sb_bus.wb_regwrite = 0; sb_bus.wb_wa = 0;
        repeat (2) @(posedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("reset_state", 0, 0, 0, 0, 0);

        // RAW on x5, cleared by the same-cycle retire
        wr(5, 0, 0);                                          checkOutput("raw_write_x5", 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); checkOutput("raw_stall", 0, 1, B5, 1, 0);
        applyStimulus(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 5); checkOutput("raw_issue_on_retire", 1, 0, B5, 1, 0);
        idle(0, 0);                                           checkOutput("raw_cleared", 0, 0, 0, 0, 0);

        // Per-register saturation on x7
        wr(7, 0, 0);
        wr(7, 0, 0);
        wr(7, 0, 0);                                          checkOutput("sat_third_write", 1, 0, B7, 2, 0);
        wr(7, 0, 0);                                          checkOutput("sat_full", 0, 1, B7, 3, 0);
        wr(7, 1, 7);                                          checkOutput("sat_full_with_retire", 0, 1, B7, 3, 0);
        wr(7, 0, 0);                                          checkOutput("sat_issue_after_retire", 1, 0, B7, 2, 0);
        idle(1, 7);                                           checkOutput("sat_back_to_3", 0, 0, B7, 3, 0);
        idle(1, 7);
        idle(1, 7);
        idle(0, 0);                                           checkOutput("sat_drained", 0, 0, 0, 0, 0);

        // Simultaneous write and retire of x9
        wr(9, 0, 0);
        wr(9, 1, 9);                                          checkOutput("simul_issue", 1, 0, B9, 1, 0);
        idle(0, 0);                                           checkOutput("simul_unchanged", 0, 0, B9, 1, 0);
        idle(1, 9);
        idle(0, 0);                                           checkOutput("simul_drained", 0, 0, 0, 0, 0);

        // Fence drain with two writes outstanding
        wr(3, 0, 0);
        wr(4, 0, 0);                                          checkOutput("fence_setup", 1, 0, B3, 1, 0);
        fence(0, 0, 0);                                       checkOutput("fence_enter", 0, 1, B3 | B4, 2, 0);
        fence(0, 1, 3);                                       checkOutput("fence_draining", 0, 1, B3 | B4, 2, 1);
        fence(0, 1, 4);                                       checkOutput("fence_issue", 1, 0, B4, 1, 1);
        idle(0, 0);                                           checkOutput("fence_run", 0, 0, 0, 0, 0);

        // Flush kills a hazarded instruction and a draining fence
        wr(8, 0, 0);
        applyStimulus(0, 1, 8, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0); checkOutput("flush_raw", 0, 0, B8, 1, 0);
        idle(0, 0);                                           checkOutput("flush_counters", 0, 0, B8, 1, 0);
        fence(0, 0, 0);                                       checkOutput("flush_fence_wait", 0, 1, B8, 1, 0);
        fence(1, 0, 0);                                       checkOutput("flush_fence_kill", 0, 0, B8, 1, 1);
        idle(1, 8);                                           checkOutput("flush_fence_run", 0, 0, B8, 1, 0);
        idle(0, 0);                                           checkOutput("flush_drained", 0, 0, 0, 0, 0);

        // Writes to x0 are never tracked
        wr(0, 0, 0);                                          checkOutput("x0_issue", 1, 0, 0, 0, 0);
        idle(0, 0);                                           checkOutput("x0_not_counted", 0, 0, 0, 0, 0);

        // EX back-pressure
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("ex_not_ready", 0, 1, 0, 0, 0);

        // Reset mid-traffic with two writes to x5 in flight
        wr(5, 0, 0);
        wr(5, 0, 0);                                          checkOutput("reset_setup", 1, 0, B5, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); checkOutput("reset_mid_traffic", 0, 0, 0, 0, 0);
        idle(0, 0);                                           checkOutput("reset_released", 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
